reception: RTL and testbench
============================

Name: reception

Overview:
- UART receiver for the board-to-board chess link; the other end of the existing multi-byte transmitter.
- Deserialises 8N1 frames (start 0, 8 data bits LSB first, stop 1) from the serial line.
- Assembles BUFFER_SIZE/8 consecutive bytes, lowest byte first, into one word.
- Presents the word with a single-cycle valid strobe to the game logic.

Parameters:
- BUFFER_SIZE, 16, word width in bits; must be a non-zero multiple of 8 (elaboration-time assertion).
- CLOCK, 65000000, clk_in frequency in Hz.
- BAUD, 9600, line bit rate.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-high.
- rx_in  input  1  asynchronous serial line; idles high.
- data_out  output  BUFFER_SIZE  last fully received word; byte k occupies bits [8k+7:8k].
- valid_out  output  1  one-cycle strobe: data_out was updated this cycle.

Behaviour:
- Clock and reset: clk_in is the clock; rst_in is asynchronous, active-high.
- Constants: DIVISOR = CLOCK/BAUD (integer division); HALF = DIVISOR/2; BYTES = BUFFER_SIZE/8.
  - baud_count width is $clog2(DIVISOR).
  - byte_idx width is $clog2(BYTES)+1.
- Synchroniser: rx_in passes through a 2-FF synchroniser (reset value 1) giving rx_s. A registered copy rx_q gives falling-edge detection (rx_q=1, rx_s=0).
- Reset values:
  - data_out=0, valid_out=0, state=IDLE.
  - byte_idx=0, baud_count=0, shift=0.
  - Synchroniser flops and rx_q = 1.
- State IDLE:
  - Waits for a falling edge on rx_s.
  - On the edge: baud_count=0, go to START.
  - A line held low (break, or low after a framing error) does not retrigger; a high level must be seen first.
- State START:
  - Counts to HALF-1, then samples rx_s at the bit centre.
  - Sample 0: baud_count=0, bit_cnt=0, go to DATA.
  - Sample 1: treated as a glitch; go to IDLE, byte_idx unchanged.
- State DATA:
  - Each time baud_count reaches DIVISOR-1: sample rx_s into shift[7] and shift right (LSB first), increment bit_cnt, reset baud_count.
  - After the 8th sample, go to STOP.
- State STOP:
  - After DIVISOR cycles, sample rx_s.
  - Sample 1: write shift into asm[8*byte_idx +: 8].
    - If byte_idx==BYTES-1, go to DONE.
    - Otherwise byte_idx++ and go to IDLE.
  - Sample 0 (framing error): discard the partial word, byte_idx=0, go to IDLE.
- State DONE (one cycle):
  - data_out<=asm, valid_out=1, byte_idx=0, go to IDLE.
  - valid_out is high exactly one cycle per word and never in back-to-back cycles.
- Latency: valid_out rises 1 clock after the final stop-bit sample (centre of the last stop bit).
- Hold: data_out holds its value until the next complete word. A partial or discarded word never changes data_out.
- Back-to-back bytes: a start edge arriving one cycle after the STOP sample must be caught, because IDLE is re-entered immediately.
- Reset mid-frame: everything returns to reset values at once. The next word is aligned from byte 0 at the next falling edge.
- No flow control: the consumer must accept data_out on the cycle of valid_out.

Optional Feature:
- Macro: RECEPTION_TIMEOUT_EN.
- Defined:
  - A counter runs while in IDLE with byte_idx!=0.
  - If no start edge arrives within 20*DIVISOR cycles, byte_idx=0 and the partial word is discarded. This resynchronises after a lost byte.
  - The counter clears on every start edge.
- Undefined: no counter; a partial word waits indefinitely for its remaining bytes.

Decomposition:
- Shared package uart_pkg holds:
  - DATA_FRAME=8.
  - The receiver state typedef, enum logic [2:0] {IDLE, START, DATA, STOP, DONE}.
  - A function computing DIVISOR from CLOCK and BAUD; this function is also used by the transmitter.
- One sub-module, uart_sync: 2-FF synchroniser plus falling-edge detector, reset to 1, outputs rx_s and fall.

Test Plan (bench uses CLOCK=160, BAUD=10, so DIVISOR=16, HALF=8; default BUFFER_SIZE=16):
- Reset released, rx_in=1 for 500 cycles -> valid_out stays 0, data_out=16'h0000.
- Send bytes 8'hA5 then 8'h3C back-to-back -> exactly one valid_out pulse, data_out=16'h3CA5, pulse 1 cycle after the second stop-bit centre.
- 4-cycle low glitch on rx_in, then byte 8'h12 and 8'h34 -> glitch ignored; data_out=16'h3412, one pulse.
- Byte 8'hFF with stop bit forced 0, then 8'h01 and 8'h02 -> first byte discarded; data_out=16'h0201 after the 8'h02 frame.
- rst_in asserted mid-DATA of the second byte, then 8'h55, 8'hAA -> no pulse from the aborted word; data_out=16'hAA55.
- With RECEPTION_TIMEOUT_EN: send 8'h11, idle 400 cycles, then 8'h22, 8'h33 -> data_out=16'h3322. Without the macro, the same stimulus gives data_out=16'h2211.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the chess-link transmitter and receiver.
package uart_pkg;

  localparam int unsigned DATA_FRAME = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } rx_state_t;

  // Clock cycles per bit; truncating division matches the transmitter.
  function automatic int unsigned calc_divisor(input int unsigned clock, input int unsigned baud);
    return clock / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge detect.
module uart_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rx_in,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  assign fall = rx_q & ~rx_s;

endmodule

// File: rtl/reception.sv
// 8N1 UART receiver assembling BUFFER_SIZE/8 bytes (lowest first) into one word.
// Define RECEPTION_TIMEOUT_EN to drop a partial word after a long inter-byte gap.
module reception
  import uart_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE = 16,
  parameter int unsigned CLOCK       = 65000000,
  parameter int unsigned BAUD        = 9600
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rx_in,
  output logic [BUFFER_SIZE-1:0] data_out,
  output logic                   valid_out
);

  localparam int unsigned DIVISOR = calc_divisor(CLOCK, BAUD);
  localparam int unsigned HALF    = DIVISOR / 2;
  localparam int unsigned BYTES   = BUFFER_SIZE / DATA_FRAME;
  localparam int unsigned BAUD_W  = $clog2(DIVISOR);
  localparam int unsigned IDX_W   = $clog2(BYTES) + 1;
  localparam int unsigned BIT_W   = $clog2(DATA_FRAME);

  if (BUFFER_SIZE == 0 || (BUFFER_SIZE % DATA_FRAME) != 0) begin : g_bad_size
    $error("reception: BUFFER_SIZE must be a non-zero multiple of 8");
  end

  logic rx_s;
  logic fall;

  uart_sync u_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rx_in  (rx_in),
    .rx_s   (rx_s),
    .fall   (fall)
  );

  rx_state_t              state, state_next;
  logic [BAUD_W-1:0]      baud_count, baud_count_next;
  logic [BIT_W-1:0]       bit_cnt, bit_cnt_next;
  logic [7:0]             shift, shift_next;
  logic [IDX_W-1:0]       byte_idx, byte_idx_next;
  logic [BUFFER_SIZE-1:0] asm_word, asm_word_next;
  logic [BUFFER_SIZE-1:0] data_next;
  logic                   valid_next;

`ifdef RECEPTION_TIMEOUT_EN
  localparam int unsigned LIMIT = 20 * DIVISOR;
  localparam int unsigned TO_W  = $clog2(LIMIT);
  logic [TO_W-1:0] to_count, to_count_next;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      baud_count <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_idx   <= '0;
      asm_word   <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
`ifdef RECEPTION_TIMEOUT_EN
      to_count   <= '0;
`endif
    end else begin
      state      <= state_next;
      baud_count <= baud_count_next;
      bit_cnt    <= bit_cnt_next;
      shift      <= shift_next;
      byte_idx   <= byte_idx_next;
      asm_word   <= asm_word_next;
      data_out   <= data_next;
      valid_out  <= valid_next;
`ifdef RECEPTION_TIMEOUT_EN
      to_count   <= to_count_next;
`endif
    end
  end

  // Frame sequencing: start-bit centre check, 8 data samples, stop-bit check.
  always_comb begin
    state_next      = state;
    baud_count_next = baud_count;
    bit_cnt_next    = bit_cnt;
    shift_next      = shift;
    byte_idx_next   = byte_idx;
    asm_word_next   = asm_word;
    data_next       = data_out;
    valid_next      = 1'b0;
`ifdef RECEPTION_TIMEOUT_EN
    to_count_next   = '0;
`endif

    case (state)
      IDLE: begin
        if (fall) begin
          baud_count_next = '0;
          state_next      = START;
        end
      end

      START: begin
        if (baud_count == BAUD_W'(HALF - 1)) begin
          if (!rx_s) begin
            baud_count_next = '0;
            bit_cnt_next    = '0;
            state_next      = DATA;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_count_next = baud_count + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_count == BAUD_W'(DIVISOR - 1)) begin
          shift_next      = {rx_s, shift[7:1]};
          baud_count_next = '0;
          bit_cnt_next    = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(DATA_FRAME - 1)) begin
            state_next = STOP;
          end
        end else begin
          baud_count_next = baud_count + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_count == BAUD_W'(DIVISOR - 1)) begin
          baud_count_next = '0;
          if (rx_s) begin
            for (int k = 0; k < int'(BYTES); k++) begin
              if (byte_idx == IDX_W'(k)) begin
                asm_word_next[8*k +: 8] = shift;
              end
            end
            if (byte_idx == IDX_W'(BYTES - 1)) begin
              state_next = DONE;
            end else begin
              byte_idx_next = byte_idx + IDX_W'(1);
              state_next    = IDLE;
            end
          end else begin
            byte_idx_next = '0;
            state_next    = IDLE;
          end
        end else begin
          baud_count_next = baud_count + BAUD_W'(1);
        end
      end

      DONE: begin
        data_next     = asm_word;
        valid_next    = 1'b1;
        byte_idx_next = '0;
        state_next    = IDLE;
      end

      default: state_next = IDLE;
    endcase

`ifdef RECEPTION_TIMEOUT_EN
    // Resynchronise after a lost byte: give up on a stale partial word.
    if (state == IDLE && byte_idx != '0 && !fall) begin
      if (to_count == TO_W'(LIMIT - 1)) begin
        byte_idx_next = '0;
      end else begin
        to_count_next = to_count + TO_W'(1);
      end
    end
`endif
  end

endmodule

// File: tb/tb_reception.sv
// Scoreboard bench for reception with CLOCK=160, BAUD=10 (16 clocks per bit).
module tb_reception;

  localparam int unsigned BIT_CYC = 16;
  localparam int unsigned LAT     = 156;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rx_in  = 1'b1;
  logic [15:0] data_out;
  logic        valid_out;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned pulses = 0;
  int unsigned p0;
  logic        prev_v = 1'b0;

  logic [15:0] exp_q[$];
  int unsigned cyc_q[$];

  reception #(
    .BUFFER_SIZE (16),
    .CLOCK       (160),
    .BAUD        (10)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output side of the scoreboard.
  always @(negedge clk_in) begin
    if (!rst_in && valid_out) begin
      pulses++;
      if (prev_v) check("valid_b2b", 1, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
        check("latency", cyc, cyc_q.pop_front());
      end
    end
    prev_v = valid_out;
  end

  task automatic idle(input int unsigned n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (BIT_CYC) @(negedge clk_in);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    rx_in = 1'b1;
  endtask

  // Final byte of a word: expect the word LAT cycles after its start bit begins.
  task automatic send_last(input logic [7:0] b, input logic [15:0] word);
    exp_q.push_back(word);
    cyc_q.push_back(cyc + LAT);
    send_byte(b, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    check("reset_data", 32'(data_out), 0);
    check("reset_valid", 32'(valid_out), 0);
    rst_in = 1'b0;

    // Idle line
    p0 = pulses;
    idle(500);
    check("idle_pulses", pulses - p0, 0);
    check("idle_data", 32'(data_out), 0);

    // Back-to-back bytes
    p0 = pulses;
    send_byte(8'hA5, 1'b1);
    send_last(8'h3C, 16'h3CA5);
    idle(40);
    check("b2b_pulses", pulses - p0, 1);

    // Short glitch must not start a frame
    p0 = pulses;
    rx_in = 1'b0;
    repeat (4) @(negedge clk_in);
    idle(30);
    send_byte(8'h12, 1'b1);
    send_last(8'h34, 16'h3412);
    idle(40);
    check("glitch_pulses", pulses - p0, 1);
    check("glitch_hold", 32'(data_out), 32'h3412);

    // Framing error discards the byte
    p0 = pulses;
    send_byte(8'hFF, 1'b0);
    idle(30);
    send_byte(8'h01, 1'b1);
    send_last(8'h02, 16'h0201);
    idle(40);
    check("frame_pulses", pulses - p0, 1);

    // Reset in the middle of the second byte
    p0 = pulses;
    send_byte(8'h77, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("midrst_data", 32'(data_out), 0);
    rst_in = 1'b0;
    idle(40);
    send_byte(8'h55, 1'b1);
    send_last(8'hAA, 16'hAA55);
    idle(40);
    check("midrst_pulses", pulses - p0, 1);

    // Long gap after the first byte of a word
    p0 = pulses;
    send_byte(8'h11, 1'b1);
    idle(400);
`ifdef RECEPTION_TIMEOUT_EN
    send_byte(8'h22, 1'b1);
    send_last(8'h33, 16'h3322);
`else
    send_last(8'h22, 16'h2211);
    send_byte(8'h33, 1'b1);
`endif
    idle(60);
    check("gap_pulses", pulses - p0, 1);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
